// File: rtl/align_arbiter_pkg.sv
// Shared definitions for the lane-FIFO to Aligner arbiter: record layout, length limit, FSM states.
package align_arbiter_pkg;

  // Lane record layout: {tag, cpr_data, len}
  localparam int unsigned TAG_MSB  = 279;
  localparam int unsigned TAG_LSB  = 264;
  localparam int unsigned DATA_MSB = 263;
  localparam int unsigned DATA_LSB = 8;
  localparam int unsigned LEN_MSB  = 7;
  localparam int unsigned LEN_LSB  = 0;

  localparam int unsigned LEN_W   = LEN_MSB - LEN_LSB + 1;
  localparam int unsigned ALIGN_W = TAG_MSB - DATA_LSB + 1;

  // Longest byte length the Aligner accepts per record
  localparam logic [LEN_W-1:0] MAX_LEN = 8'd32;

  typedef enum logic [1:0] {
    StIdle,
    StServe,
    StDrain,
    StDone
  } arb_state_e;

  // Clamp a record length to what the Aligner can take
  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

endpackage

// File: rtl/align_arbiter_rr_picker.sv
// Combinational round-robin finder: first requesting index strictly after ptr_i, wrapping,
// with ptr_i itself considered last.
module rr_picker #(
  parameter int unsigned NumReq = 4
) (
  input  logic [NumReq-1:0]         req_i,
  input  logic [$clog2(NumReq)-1:0] ptr_i,
  output logic [$clog2(NumReq)-1:0] gnt_idx_o,
  output logic                      valid_o
);

  localparam int unsigned IdxW = $clog2(NumReq);

  logic [IdxW-1:0] idx;

  // Scan farthest-first so the nearest requester after ptr_i wins; NumReq is a power of two,
  // so the index add wraps for free.
  always_comb begin
    gnt_idx_o = ptr_i;
    valid_o   = 1'b0;
    idx       = ptr_i;
    for (int i = int'(NumReq); i >= 1; i--) begin
      idx = ptr_i + IdxW'(i);
      if (req_i[idx]) begin
        gnt_idx_o = idx;
        valid_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/align_arbiter.sv
// Arbitrates show-ahead compressor lane FIFOs onto one Aligner write port, with bursting,
// back-pressure, zero-length record dropping and an end-of-stream flush handshake.
module align_arbiter
  import align_arbiter_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned REC_WIDTH = 280,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_LANES-1:0]           lane_empty,
  input  logic [NUM_LANES*REC_WIDTH-1:0] lane_data,
  output logic [NUM_LANES-1:0]           lane_pop,
  input  logic                           align_stall,
  output logic                           align_wrt_en,
  output logic [ALIGN_W-1:0]             align_data,
  output logic [LEN_W-1:0]               align_len,
  output logic [$clog2(NUM_LANES)-1:0]   align_lane,
  input  logic                           flush_req,
  output logic                           flush_done,
  output logic                           busy,
  output logic [31:0]                    rec_count
);

  localparam int unsigned LaneW  = $clog2(NUM_LANES);
  localparam int unsigned BurstW = $clog2(BURST_MAX + 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(BURST_MAX);

  arb_state_e               state_q;
  logic [LaneW-1:0]         cur_q;
  logic [BurstW-1:0]        burst_q;
  logic                     wrt_en_q;
  logic [ALIGN_W-1:0]       data_q;
  logic [LEN_W-1:0]         len_q;
  logic [LaneW-1:0]         lane_q;
  logic [31:0]              cnt_q;

  logic [LaneW-1:0]         pick_idx;
  logic                     pick_valid;
  logic [LaneW-1:0]         sel_idx;
  logic                     sel_valid;
  logic                     keep;
  logic                     grant;
  logic                     any_req;
  logic [REC_WIDTH-1:0]     head_rec;
  logic [LEN_W-1:0]         head_len;

  rr_picker #(
    .NumReq (NUM_LANES)
  ) u_rr_picker (
    .req_i     (~lane_empty),
    .ptr_i     (cur_q),
    .gnt_idx_o (pick_idx),
    .valid_o   (pick_valid)
  );

  // Lane selection and grant; burst_q == 0 means no lane owned yet, so rotation starts at lane 0.
  always_comb begin
    any_req   = |(~lane_empty);
    keep      = (burst_q != '0) && (burst_q < BurstMax) && !lane_empty[cur_q];
    sel_idx   = keep ? cur_q : pick_idx;
    sel_valid = keep | pick_valid;
    grant     = ((state_q == StServe) || (state_q == StDrain)) && !align_stall && sel_valid;
    head_rec  = lane_data[int'(sel_idx)*REC_WIDTH +: REC_WIDTH];
    head_len  = head_rec[LEN_MSB:LEN_LSB];
  end

  // Pop strobe goes out in the grant cycle so the FIFO head advances on the same edge.
  always_comb begin
    lane_pop = '0;
    if (grant) begin
      lane_pop[sel_idx] = 1'b1;
    end
  end

  // FSM, burst tracking and registered Aligner outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cur_q    <= LaneW'(NUM_LANES - 1);
      burst_q  <= '0;
      wrt_en_q <= 1'b0;
      data_q   <= '0;
      len_q    <= '0;
      lane_q   <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (flush_req) begin
            state_q <= StDrain;
          end else if (any_req) begin
            state_q <= StServe;
          end
        end
        StServe: begin
          if (flush_req) begin
            state_q <= StDrain;
          end else if (!any_req) begin
            state_q <= StIdle;
          end
        end
        StDrain: begin
          if (!any_req && !align_stall) begin
            state_q <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      wrt_en_q <= 1'b0;
      if (grant) begin
        // Zero-length records are consumed but never reach the Aligner.
        if (head_len != '0) begin
          wrt_en_q <= 1'b1;
          data_q   <= {head_rec[TAG_MSB:TAG_LSB], head_rec[DATA_MSB:DATA_LSB]};
          len_q    <= sat_len(head_len);
          lane_q   <= sel_idx;
          cnt_q    <= cnt_q + 32'd1;
        end
        if ((burst_q != '0) && (sel_idx == cur_q)) begin
          if (burst_q < BurstMax) begin
            burst_q <= burst_q + BurstW'(1);
          end
        end else begin
          burst_q <= BurstW'(1);
          cur_q   <= sel_idx;
        end
      end
    end
  end

  assign align_wrt_en = wrt_en_q;
  assign align_data   = data_q;
  assign align_len    = len_q;
  assign align_lane   = lane_q;
  assign rec_count    = cnt_q;
  assign busy         = (state_q != StIdle);
  assign flush_done   = (state_q == StDone);

endmodule

// File: tb/tb_align_arbiter.sv
// Self-checking bench for align_arbiter: directed scenarios plus a randomized phase, all checked
// against a transaction-level model of the arbitration rules.
module tb_align_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned RW = 280;
  localparam int unsigned BM = 4;

  typedef logic [271:0] val_t;
  typedef enum int {MIdle, MServe, MDrain, MDone} mstate_e;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      lane_empty;
  logic [N*RW-1:0]   lane_data;
  logic [N-1:0]      lane_pop;
  logic              align_stall;
  logic              align_wrt_en;
  logic [271:0]      align_data;
  logic [7:0]        align_len;
  logic [1:0]        align_lane;
  logic              flush_req;
  logic              flush_done;
  logic              busy;
  logic [31:0]       rec_count;

  align_arbiter #(
    .NUM_LANES (N),
    .REC_WIDTH (RW),
    .BURST_MAX (BM)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .lane_empty   (lane_empty),
    .lane_data    (lane_data),
    .lane_pop     (lane_pop),
    .align_stall  (align_stall),
    .align_wrt_en (align_wrt_en),
    .align_data   (align_data),
    .align_len    (align_len),
    .align_lane   (align_lane),
    .flush_req    (flush_req),
    .flush_done   (flush_done),
    .busy         (busy),
    .rec_count    (rec_count)
  );

  always #5 clk = ~clk;

  // Lane FIFO contents
  logic [RW-1:0] fifo [N][$];

  // Reference model state
  mstate_e     m_state;
  int          m_cur;
  int          m_burst;
  int unsigned m_cnt;
  logic        exp_wrt;
  val_t        exp_data;
  logic [7:0]  exp_len;
  logic [1:0]  exp_lane;

  // Observation tallies
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tot_pops = 0;
  int   tot_wrt  = 0;
  int   tot_flush = 0;
  int   gnt_log[$];
  val_t last_data;
  logic [7:0] last_len;

  task automatic check_val(input string tag, input val_t got, input val_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_heads();
    for (int i = 0; i < int'(N); i++) begin
      lane_empty[i] = (fifo[i].size() == 0);
      lane_data[i*RW +: RW] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
    end
  endtask

  function automatic logic [RW-1:0] rand_rec(input logic [7:0] len);
    logic [287:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
         $urandom};
    t[7:0] = len;
    return t[RW-1:0];
  endfunction

  function automatic logic [7:0] rand_len();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 8'd0;
    if (r <= 2) return 8'($urandom_range(33, 255));
    return 8'($urandom_range(1, 32));
  endfunction

  task automatic model_reset();
    m_state  = MIdle;
    m_cur    = N - 1;
    m_burst  = 0;
    m_cnt    = 0;
    exp_wrt  = 1'b0;
    exp_data = '0;
    exp_len  = '0;
    exp_lane = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_pop"},   val_t'(lane_pop), '0);
    check_val({tag, "_wrt"},   val_t'(align_wrt_en), '0);
    check_val({tag, "_data"},  align_data, '0);
    check_val({tag, "_len"},   val_t'(align_len), '0);
    check_val({tag, "_lane"},  val_t'(align_lane), '0);
    check_val({tag, "_fdone"}, val_t'(flush_done), '0);
    check_val({tag, "_busy"},  val_t'(busy), '0);
    check_val({tag, "_cnt"},   val_t'(rec_count), '0);
  endtask

  // One clock: predict this cycle's pop, compare, advance FIFOs and model, compare outputs.
  task automatic cycle();
    logic [N-1:0]  exp_pop;
    logic [N-1:0]  obs_pop;
    logic [RW-1:0] rec;
    int            sel;
    bit            grant;
    bit            any;
    @(negedge clk);
    any     = (lane_empty != '1);
    exp_pop = '0;
    grant   = 1'b0;
    sel     = -1;
    if ((m_state == MServe || m_state == MDrain) && !align_stall) begin
      if (m_burst > 0 && m_burst < int'(BM) && !lane_empty[m_cur]) begin
        sel = m_cur;
      end else begin
        for (int i = 1; i <= int'(N); i++) begin
          if (sel < 0 && !lane_empty[(m_cur + i) % N]) sel = (m_cur + i) % N;
        end
      end
      if (sel >= 0) begin
        grant = 1'b1;
        exp_pop[sel] = 1'b1;
      end
    end
    obs_pop = lane_pop;
    check_val("lane_pop", val_t'(obs_pop), val_t'(exp_pop));
    tot_pops += $countones(obs_pop);
    for (int i = 0; i < int'(N); i++) if (obs_pop[i]) gnt_log.push_back(i);

    exp_wrt = 1'b0;
    if (grant) begin
      rec = fifo[sel][0];
      if (rec[7:0] != 0) begin
        exp_wrt  = 1'b1;
        exp_data = rec[279:8];
        exp_len  = (rec[7:0] > 8'd32) ? 8'd32 : rec[7:0];
        exp_lane = 2'(sel);
        m_cnt++;
      end
      if (m_burst > 0 && sel == m_cur) begin
        if (m_burst < int'(BM)) m_burst++;
      end else begin
        m_burst = 1;
        m_cur   = sel;
      end
    end
    case (m_state)
      MIdle:   if (flush_req) m_state = MDrain; else if (any) m_state = MServe;
      MServe:  if (flush_req) m_state = MDrain; else if (!any) m_state = MIdle;
      MDrain:  if (!any && !align_stall) m_state = MDone;
      default: m_state = MIdle;
    endcase

    @(posedge clk);
    #1;
    if (grant) void'(fifo[sel].pop_front());
    drive_heads();
    check_val("wrt_en", val_t'(align_wrt_en), val_t'(exp_wrt));
    check_val("data", align_data, exp_data);
    check_val("len", val_t'(align_len), val_t'(exp_len));
    check_val("lane", val_t'(align_lane), val_t'(exp_lane));
    check_val("rec_count", val_t'(rec_count), val_t'(m_cnt));
    check_val("busy", val_t'(busy), val_t'(m_state != MIdle));
    check_val("flush_done", val_t'(flush_done), val_t'(m_state == MDone));
    if (align_wrt_en) begin
      tot_wrt++;
      last_data = align_data;
      last_len  = align_len;
    end
    if (flush_done) tot_flush++;
  endtask

  task automatic run_until_idle(input int max_cycles);
    int  n;
    bit  all_empty;
    n = 0;
    all_empty = 1'b0;
    while (n < max_cycles) begin
      all_empty = 1'b1;
      for (int i = 0; i < int'(N); i++) if (fifo[i].size() != 0) all_empty = 1'b0;
      if (all_empty && m_state == MIdle) break;
      cycle();
      n++;
    end
    if (n >= max_cycles) check_val("idle_timeout", val_t'(n), val_t'(max_cycles - 1));
  endtask

  initial begin
    int   p0, w0, f0, e;
    val_t basic_data;

    reset       = 1'b0;
    align_stall = 1'b0;
    flush_req   = 1'b0;
    lane_empty  = '1;
    lane_data   = '0;
    model_reset();
    drive_heads();
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Equal load on all lanes: bursts of BM then rotation
    gnt_log.delete();
    for (int l = 0; l < int'(N); l++)
      for (int k = 0; k < 6; k++) fifo[l].push_back(rand_rec(8'($urandom_range(1, 255))));
    drive_heads();
    run_until_idle(200);
    check_val("rr_count", val_t'(rec_count), val_t'(24));
    check_val("rr_pops", val_t'(gnt_log.size()), val_t'(24));
    if (gnt_log.size() == 24) begin
      for (int k = 0; k < 24; k++) begin
        e = (k < 16) ? k / 4 : (k - 16) / 2;
        check_val("rr_order", val_t'(gnt_log[k]), val_t'(e));
      end
    end

    // Single known record on lane 0
    basic_data = {16'h46DB, 128'h1234_5678_9ABC_DEF1_2345_6789_ABCD_EF00, 128'h0};
    w0 = tot_wrt;
    fifo[0].push_back({basic_data, 8'h0F});
    drive_heads();
    run_until_idle(20);
    check_val("basic_wrts", val_t'(tot_wrt - w0), val_t'(1));
    check_val("basic_data", last_data, basic_data);
    check_val("basic_len", val_t'(last_len), val_t'(8'h0F));

    // Stall in the middle of a burst
    for (int k = 0; k < 6; k++) fifo[3].push_back(rand_rec(8'($urandom_range(1, 32))));
    drive_heads();
    repeat (3) cycle();
    align_stall = 1'b1;
    p0 = tot_pops;
    w0 = tot_wrt;
    repeat (3) cycle();
    check_val("stall_pops", val_t'(tot_pops - p0), '0);
    check_val("stall_wrts", val_t'(tot_wrt - w0), '0);
    align_stall = 1'b0;
    run_until_idle(50);

    // Zero-length record is consumed but not forwarded
    p0 = tot_pops;
    w0 = tot_wrt;
    fifo[1].push_back(rand_rec(8'h0B));
    fifo[1].push_back(rand_rec(8'h00));
    fifo[1].push_back(rand_rec(8'h07));
    drive_heads();
    run_until_idle(30);
    check_val("len0_pops", val_t'(tot_pops - p0), val_t'(3));
    check_val("len0_wrts", val_t'(tot_wrt - w0), val_t'(2));
    check_val("len0_last_len", val_t'(last_len), val_t'(8'h07));

    // Flush with two records queued on lane 2
    w0 = tot_wrt;
    f0 = tot_flush;
    fifo[2].push_back(rand_rec(8'd40));
    fifo[2].push_back(rand_rec(8'd5));
    drive_heads();
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    run_until_idle(30);
    check_val("flush_wrts", val_t'(tot_wrt - w0), val_t'(2));
    check_val("flush_pulses", val_t'(tot_flush - f0), val_t'(1));

    // Randomized traffic, stalls and flushes
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        fifo[$urandom_range(0, N - 1)].push_back(rand_rec(rand_len()));
        drive_heads();
      end
      align_stall = ($urandom_range(0, 3) == 0);
      flush_req   = ($urandom_range(0, 29) == 0);
      cycle();
    end
    align_stall = 1'b0;
    flush_req   = 1'b0;
    run_until_idle(600);

    // Reset in the middle of a burst, then restart from lane 0
    for (int k = 0; k < 4; k++) begin
      fifo[1].push_back(rand_rec(8'd9));
      fifo[2].push_back(rand_rec(8'd9));
    end
    drive_heads();
    repeat (3) cycle();
    fifo[0].push_back(rand_rec(8'd3));
    fifo[0].push_back(rand_rec(8'd4));
    drive_heads();
    cycle();
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    gnt_log.delete();
    repeat (2) cycle();
    check_val("post_reset_grants", val_t'(gnt_log.size()), val_t'(1));
    if (gnt_log.size() != 0) check_val("post_reset_lane", val_t'(gnt_log[0]), '0);
    run_until_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/align_arbiter.md
ALIGN_ARBITER -- requirements
Module: align_arbiter

Interface
REQ-001 Parameter NUM_LANES, default 4, number of compressor lane FIFOs feeding one Aligner (power of two, 2..8).
REQ-002 Parameter REC_WIDTH, default 280, lane record width {tag[279:264], cpr_data[263:8], len[7:0]}.
REQ-003 Parameter BURST_MAX, default 4, max consecutive records granted to one lane before rotation.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 lane_empty  in  NUM_LANES  per-lane FIFO empty flag.
REQ-008 lane_data  in  NUM_LANES*REC_WIDTH  per-lane FIFO head record, lane i at bits [i*REC_WIDTH +: REC_WIDTH], show-ahead (valid when lane_empty[i]=0).
REQ-009 lane_pop  out  NUM_LANES  one-hot pop strobe; FIFO head advances after the edge.
REQ-010 align_stall  in  1  Aligner back-pressure.
REQ-011 align_wrt_en  out  1  record-valid strobe to Aligner.
REQ-012 align_data  out  272  registered {tag, cpr_data} to Aligner.
REQ-013 align_len  out  8  registered byte length to Aligner.
REQ-014 align_lane  out  log2(NUM_LANES)  lane index of current align_data.
REQ-015 flush_req  in  1  single-cycle end-of-stream request.
REQ-016 flush_done  out  1  single-cycle pulse when flush completes.
REQ-017 busy  out  1  high in any state except IDLE.
REQ-018 rec_count  out  32  forwarded-record counter, wraps modulo 2^32.

Function
REQ-019 States SHALL be IDLE, SERVE, DRAIN, DONE.
REQ-020 IDLE->SERVE when any lane non-empty; IDLE->DRAIN on flush_req.
REQ-021 SERVE->IDLE when all lanes empty and no flush pending; SERVE->DRAIN on flush_req.
REQ-022 DRAIN->DONE when all lanes empty and align_stall=0; DONE->IDLE unconditionally after one cycle, flush_done=1 in DONE only.
REQ-023 Grant SHALL occur in a cycle only if state is SERVE or DRAIN, align_stall=0, and the selected lane is non-empty.
REQ-024 Selection: keep current lane while non-empty and burst count < BURST_MAX; else round-robin to next non-empty lane after current, index wrapping NUM_LANES-1 -> 0.
REQ-025 On grant: lane_pop[sel]=1 that cycle (combinational); next cycle align_data/align_len/align_lane hold the record and align_wrt_en=1 — latency exactly 1 cycle.
REQ-026 Records with len=0 SHALL be popped but not forwarded (align_wrt_en stays 0, rec_count unchanged).
REQ-027 len > 32 SHALL be saturated to 32 on align_len.
REQ-028 align_stall=1: no pop, align_wrt_en=0 next cycle, align_data/align_len hold last values.
REQ-029 Burst counter resets to 1 on lane change, increments per grant to same lane, saturates at BURST_MAX.
REQ-030 flush_req while in DRAIN or DONE SHALL be ignored; flush_req and a grant in the same cycle both take effect.
REQ-031 At most one lane_pop bit high per cycle; never pop an empty lane.
REQ-032 rec_count increments by one per align_wrt_en pulse.

Reset
REQ-033 On reset low: state IDLE, lane_pop=0, align_wrt_en=0, align_data=0, align_len=0, align_lane=0, flush_done=0, busy=0, rec_count=0, burst count 0, current lane pointer NUM_LANES-1 (first grant lands on lane 0).
REQ-034 Reset mid-burst or mid-drain SHALL abort immediately; no pop in the cycle after release unless a normal grant condition holds.

Structure
REQ-035 Shared package holds record field offsets (TAG/DATA/LEN positions), MAX_LEN=32, and state encoding.
REQ-036 One sub-module, rr_picker: combinational round-robin next-lane finder (request vector, current pointer -> grant index, valid).

Verification
REQ-037 Lane0 holds {16'h46DB, 256'h1234_5678_9ABC_DEF1_2345_6789_ABCD_EF00_0…, 8'h0F}, others empty -> lane_pop[0] cycle N, align_wrt_en with that data and len 8'h0F at N+1.
REQ-038 Lanes 0..3 each hold 6 records, BURST_MAX=4 -> grant order 0,0,0,0,1,1,1,1,2,… ; rec_count=24 at end.
REQ-039 align_stall high 3 cycles during a burst -> no pop, align_wrt_en=0, align_data held; resumes same lane, burst count preserved.
REQ-040 Lane1 record len=8'h00 between len 8'h0B and 8'h07 records -> three pops, two align_wrt_en pulses.
REQ-041 flush_req with 2 records queued on lane 2 -> both forwarded, flush_done one cycle after last pop with stall low, then IDLE.
REQ-042 Reset asserted mid-burst -> all outputs zero asynchronously, rec_count=0, next grant after release targets lane 0.
